line_buffer_3row: RTL and testbench
===================================

Name: line_buffer_3row

Overview:
- Upstream feeder of the 3x3 convolution stage.
- Accepts one raster pixel stream with dv/hs/vs timing.
- Stores the two previous active lines in on-chip line RAMs.
- Emits three vertically aligned pixels per cycle (current, line-1, line-2) with timing signals delayed to match, so the convolution's vect_in_0/1/2 and dv/hs/vs inputs connect directly.

Parameters:
- COLORDEPTH, 8: bits per pixel component.
- SCREENWIDTH, 1600: maximum active pixels per line; line RAM depth.
- AW, $clog2(SCREENWIDTH): column address width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- px_i  in  COLORDEPTH  input pixel, valid when dv_i=1
- dv_i  in  1  data valid (active video)
- hs_i  in  1  horizontal sync
- vs_i  in  1  vertical sync; high = frame boundary
- row0_o  out  COLORDEPTH  current-line pixel (to vect_in_0)
- row1_o  out  COLORDEPTH  previous-line pixel, same column (to vect_in_1)
- row2_o  out  COLORDEPTH  line-2 pixel, same column (to vect_in_2)
- dv_o  out  1  dv_i delayed 1 cycle
- hs_o  out  1  hs_i delayed 1 cycle
- vs_o  out  1  vs_i delayed 1 cycle
- line_end_o  out  1  one-cycle pulse on the cycle dv_o falls
- ovf_o  out  1  sticky line-overflow flag

Behaviour:
- Reset: all outputs 0; col counter 0; line counter 0; ovf_o 0. RAM contents are not cleared.
- Latency: exactly 1 clk for every output relative to the inputs.
- Column counter col[AW-1:0]:
  - Increments on each cycle with dv_i=1.
  - Clears to 0 on the first cycle with dv_i=0 after dv_i=1 (line end), and whenever vs_i=1.
- RAM write/read on each cycle with dv_i=1 (read-before-write, same address col):
  - rd1 = ram0[col], rd2 = ram1[col].
  - ram0[col] <= px_i; ram1[col] <= rd1.
  - row0_o <= px_i; row1_o <= rd1 masked; row2_o <= rd2 masked.
- With dv_i=0: row0_o/row1_o/row2_o <= 0 and RAMs are not written.
- Line counter lcnt[1:0]:
  - Saturating at 2.
  - Increments on each dv_i falling edge.
  - Clears when vs_i=1.
- Masking (macro off):
  - row1_o forced 0 while lcnt==0.
  - row2_o forced 0 while lcnt<2.
  - Stale data from the previous frame never reaches the outputs.
- line_end_o: registered pulse, 1 when dv_o=1 and dv_i=0 in the same cycle (i.e. aligned with the last valid output pixel + 1, the cycle dv_o goes low).
- Overflow:
  - If dv_i=1 while col==SCREENWIDTH-1 and the prior cycle also wrote at SCREENWIDTH-1, col holds at SCREENWIDTH-1 (no wrap).
  - The write proceeds (overwriting the last column) and ovf_o sets.
  - ovf_o clears only on vs_i=1 or rst.
- Simultaneous events:
  - vs_i=1 with dv_i=1: vs clear wins for col and lcnt. The pixel is still written at col 0 and output with row1_o/row2_o masked.
  - dv falling in the same cycle as vs_i=1: lcnt clears (no increment).
- Reset mid-line: counters and outputs return to 0 next cycle. The next line after reset is treated as line 0 (masked).

Optional Feature:
- Macro LB_EDGE_REPLICATE_EN.
- Defined: top-border replication instead of zero padding.
  - While lcnt==0: row1_o = row2_o = px_i.
  - While lcnt==1: row2_o = rd1 (row1 value).
  - Matches clamp-to-edge for the convolution.
- Undefined: zero masking as in Behaviour; no extra muxes synthesised.

Test Plan (SCREENWIDTH=4, COLORDEPTH=8):
- Reset: rst=1 for 2 cycles while driving dv_i=1, px_i=0xFF -> all outputs 0, ovf_o=0.
- Three lines after vs pulse:
  - Stimulus: line A=10,11,12,13; line B=20..23; line C=30..33, 2 idle cycles between lines.
  - Line A output: row0=10..13, row1=row2=0.
  - Line B output: row0=20..23, row1=10..13, row2=0.
  - Line C output: row0=30..33, row1=20..23, row2=10..13. All 1 cycle after input.
- Timing alignment: dv_o/hs_o/vs_o equal dv_i/hs_i/vs_i delayed 1 cycle. line_end_o is high exactly once per line, on the cycle dv_o falls.
- Overflow: a 6-pixel line 1..6 -> col holds 3, ram0[3]=6, ovf_o=1 and stays 1 until the next vs_i=1, then 0.
- Frame restart: a vs pulse after line C, then line D=40..43 -> row1=row2=0 (no stale 30..33 leakage).
- LB_EDGE_REPLICATE_EN defined, repeat the three-line test:
  - Line A: row1=row2=10..13.
  - Line B: row2=10..13.
  - Line C: unchanged.

Source files
------------

// File: rtl/line_buffer_3row.sv
// Three-row line buffer feeding the 3x3 convolution: current pixel plus the two previous lines, same column.
// Optional macro LB_EDGE_REPLICATE_EN selects top-border replication instead of zero padding.
module line_buffer_3row #(
    parameter int COLORDEPTH  = 8,
    parameter int SCREENWIDTH = 1600,
    localparam int AW = $clog2(SCREENWIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] row0_o,
    output logic [COLORDEPTH-1:0] row1_o,
    output logic [COLORDEPTH-1:0] row2_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  line_end_o,
    output logic                  ovf_o
);

    logic [COLORDEPTH-1:0] ram0 [SCREENWIDTH];
    logic [COLORDEPTH-1:0] ram1 [SCREENWIDTH];

    logic [AW-1:0]         col;
    logic [1:0]            lcnt;
    logic                  wrote_last;
    logic [AW-1:0]         wr_addr;
    logic [1:0]            lc_eff;
    logic                  col_last;
    logic [COLORDEPTH-1:0] rd1;
    logic [COLORDEPTH-1:0] rd2;
    logic [COLORDEPTH-1:0] row1_n;
    logic [COLORDEPTH-1:0] row2_n;

    // A vs_i cycle behaves as column 0 of line 0, even if dv_i is high.
    always_comb begin
        wr_addr  = vs_i ? '0 : col;
        lc_eff   = vs_i ? 2'd0 : lcnt;
        col_last = (col == AW'(SCREENWIDTH - 1));
        rd1      = ram0[wr_addr];
        rd2      = ram1[wr_addr];
`ifdef LB_EDGE_REPLICATE_EN
        row1_n   = (lc_eff == 2'd0) ? px_i : rd1;
        row2_n   = (lc_eff == 2'd0) ? px_i : ((lc_eff == 2'd1) ? rd1 : rd2);
`else
        row1_n   = (lc_eff == 2'd0) ? '0 : rd1;
        row2_n   = (lc_eff == 2'd2) ? rd2 : '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst && dv_i) begin
            ram0[wr_addr] <= px_i;
            ram1[wr_addr] <= rd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            lcnt       <= 2'd0;
            wrote_last <= 1'b0;
            row0_o     <= '0;
            row1_o     <= '0;
            row2_o     <= '0;
            dv_o       <= 1'b0;
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            line_end_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            dv_o       <= dv_i;
            hs_o       <= hs_i;
            vs_o       <= vs_i;
            line_end_o <= dv_o && !dv_i;
            wrote_last <= dv_i && !vs_i && col_last;

            if (dv_i) begin
                row0_o <= px_i;
                row1_o <= row1_n;
                row2_o <= row2_n;
            end else begin
                row0_o <= '0;
                row1_o <= '0;
                row2_o <= '0;
            end

            // Column saturates at the last address; a second write there flags overflow.
            if (vs_i || !dv_i)
                col <= '0;
            else if (!col_last)
                col <= col + 1'b1;

            if (vs_i)
                ovf_o <= 1'b0;
            else if (dv_i && col_last && wrote_last)
                ovf_o <= 1'b1;

            if (vs_i)
                lcnt <= 2'd0;
            else if (dv_o && !dv_i && lcnt != 2'd2)
                lcnt <= lcnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Randomized plus directed bench for line_buffer_3row (SCREENWIDTH=4) against a line-history reference model.
// Honours LB_EDGE_REPLICATE_EN when defined for both DUT and model.
module tb_line_buffer_3row;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] px_i;
    logic       dv_i, hs_i, vs_i;
    logic [7:0] row0_o, row1_o, row2_o;
    logic       dv_o, hs_o, vs_o, line_end_o, ovf_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    line_buffer_3row #(.COLORDEPTH(8), .SCREENWIDTH(W)) dut (
        .clk(clk), .rst(rst), .px_i(px_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .row0_o(row0_o), .row1_o(row1_o), .row2_o(row2_o),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .line_end_o(line_end_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // Reference model: per column, the newest pixel and the one it displaced;
    // lines completed since the frame started decide what is visible.
    int   last_px [W];
    int   older_px[W];
    int   pos, lines_done, writes_at_end;
    bit   was_active, overflowed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic h, input logic s, input logic [7:0] p);
        int e0, e1, e2, idx, lines;
        bit eend, edv, ehs, evs;
        rst = r; dv_i = v; hs_i = h; vs_i = s; px_i = p;
        e0 = 0; e1 = 0; e2 = 0; eend = 0; edv = 0; ehs = 0; evs = 0;
        if (r) begin
            pos = 0; lines_done = 0; writes_at_end = 0; was_active = 0; overflowed = 0;
        end else begin
            edv = v; ehs = h; evs = s;
            eend = was_active && !v;
            idx   = s ? 0 : pos;
            lines = s ? 0 : lines_done;
            if (v) begin
                e0 = p;
`ifdef LB_EDGE_REPLICATE_EN
                e1 = (lines == 0) ? p : last_px[idx];
                e2 = (lines == 0) ? p : (lines == 1) ? last_px[idx] : older_px[idx];
`else
                e1 = (lines >= 1) ? last_px[idx] : 0;
                e2 = (lines >= 2) ? older_px[idx] : 0;
`endif
                older_px[idx] = last_px[idx];
                last_px[idx]  = p;
            end
            if (s) overflowed = 0;
            else if (v && idx == W - 1) begin
                writes_at_end++;
                if (writes_at_end >= 2) overflowed = 1;
            end
            if (s || !v) writes_at_end = 0;
            if (s) lines_done = 0;
            else if (was_active && !v) lines_done = (lines_done >= 2) ? 2 : lines_done + 1;
            if (s || !v) pos = 0;
            else pos = (pos + 1 > W - 1) ? W - 1 : pos + 1;
            was_active = v;
        end
        @(posedge clk);
        #1;
        check("row0", 32'(row0_o), 32'(e0));
        check("row1", 32'(row1_o), 32'(e1));
        check("row2", 32'(row2_o), 32'(e2));
        check("dv", 32'(dv_o), 32'(edv));
        check("hs", 32'(hs_o), 32'(ehs));
        check("vs", 32'(vs_o), 32'(evs));
        check("line_end", 32'(line_end_o), 32'(eend));
        check("ovf", 32'(ovf_o), 32'(overflowed));
    endtask

    task automatic send_line(input int base, input int len, input int idle);
        for (int i = 0; i < len; i++) step(0, 1, 0, 0, 8'(base + i));
        step(0, 0, 1, 0, 8'h00);
        for (int i = 1; i < idle; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        for (int c = 0; c < W; c++) begin last_px[c] = 0; older_px[c] = 0; end
        pos = 0; lines_done = 0; writes_at_end = 0; was_active = 0; overflowed = 0;
        rst = 1; dv_i = 0; hs_i = 0; vs_i = 0; px_i = 0;

        // Reset while the input looks like live video.
        step(1, 1, 0, 0, 8'hFF);
        step(1, 1, 0, 0, 8'hFF);
        check("reset_row0", 32'(row0_o), 32'd0);
        check("reset_ovf", 32'(ovf_o), 32'd0);

        // Directed: vs, lines A/B/C, overflow line, new frame, line D.
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        send_line(10, 4, 2);
        send_line(20, 4, 2);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 8'(30 + i));
            check("lineC_row2_explicit", 32'(row2_o), 32'(10 + i));
        end
        step(0, 0, 1, 0, 8'h00);
        check("lineC_end", 32'(line_end_o), 32'd1);
        step(0, 0, 0, 0, 8'h00);
        send_line(1, 6, 3);
        check("ovf_sticky", 32'(ovf_o), 32'd1);
        step(0, 0, 0, 1, 8'h00);
        check("ovf_cleared", 32'(ovf_o), 32'd0);
        step(0, 0, 0, 0, 8'h00);
        send_line(40, 4, 2);

        // Randomized frames, variable line lengths, occasional reset and vs-with-dv.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0) step(1, 1'($urandom), 0, 0, 8'($urandom));
            step(0, 1'($urandom_range(0, 3) == 0), 0, 1, 8'($urandom));
            step(0, 0, 0, 0, 8'h00);
            for (int l = 0; l < int'($urandom_range(1, 5)); l++) begin
                int len;
                len = int'($urandom_range(1, 7));
                for (int i = 0; i < len; i++)
                    step(0, 1, 1'($urandom), 0, 8'($urandom));
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    step(0, 0, 1'($urandom), 0, 8'h00);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
